// File: rtl/connect6_move_rx.sv
// Receive framing for Connect Six moves: polls the RS232 core FIFO, assembles
// A5/X1/Y1/X2/Y2/CHK frames, presents validated moves, and pulses frame errors.
module connect6_move_rx #(
  parameter int          BOARD_SIZE     = 19,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] uart_readdata,
  output logic        uart_read,
  output logic        move_valid,
  input  logic        move_ready,
  output logic [4:0]  move_x1,
  output logic [4:0]  move_y1,
  output logic [4:0]  move_x2,
  output logic [4:0]  move_y2,
  output logic        move_single,
  output logic        err_valid,
  output logic [1:0]  err_code
);

  // state  | meaning
  // F_IDLE | wait for a non-empty FIFO and no move pending
  // F_RD   | one-cycle read strobe to the RS232 core
  // F_CAP  | byte valid on readdata, handed to the parser
  // F_GAP1 | settle cycle while the FIFO count updates
  // F_GAP2 | second settle cycle
  localparam logic [2:0] F_IDLE = 3'd0;
  localparam logic [2:0] F_RD   = 3'd1;
  localparam logic [2:0] F_CAP  = 3'd2;
  localparam logic [2:0] F_GAP1 = 3'd3;
  localparam logic [2:0] F_GAP2 = 3'd4;

  localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
  localparam logic [7:0]  NO_STONE   = 8'hFF;
  localparam logic [7:0]  BOARD_LIM  = 8'(BOARD_SIZE);
  localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_CHK   = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  logic [2:0]  fetch_q, fetch_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic [31:0] tmo_q, tmo_d;
  logic        move_valid_q, move_valid_d;
  logic [4:0]  move_x1_q, move_x1_d, move_y1_q, move_y1_d;
  logic [4:0]  move_x2_q, move_x2_d, move_y2_q, move_y2_d;
  logic        move_single_q, move_single_d;
  logic        err_valid_q, err_valid_d;
  logic [1:0]  err_code_q, err_code_d;

  logic [6:0] fifo_cnt;
  logic [7:0] rx_byte;
  logic       byte_stb;
  logic       chk_ok, single, range_ok;
  logic       unused_readdata;

  assign fifo_cnt        = uart_readdata[22:16];
  assign rx_byte         = uart_readdata[7:0];
  assign unused_readdata = ^{uart_readdata[31:23], uart_readdata[15:8]};
  assign byte_stb        = (fetch_q == F_CAP);

  // Frame checks evaluated against the CHK byte as it is captured.
  assign chk_ok   = (rx_byte == (x1_q ^ y1_q ^ x2_q ^ y2_q));
  assign single   = (x2_q == NO_STONE) && (y2_q == NO_STONE);
  assign range_ok = (x1_q < BOARD_LIM) && (y1_q < BOARD_LIM) &&
                    (single || ((x2_q < BOARD_LIM) && (y2_q < BOARD_LIM) &&
                                !((x2_q == x1_q) && (y2_q == y1_q))));

  always_comb begin
    fetch_d       = fetch_q;
    idx_d         = idx_q;
    x1_d          = x1_q;
    y1_d          = y1_q;
    x2_d          = x2_q;
    y2_d          = y2_q;
    tmo_d         = tmo_q;
    move_valid_d  = move_valid_q;
    move_x1_d     = move_x1_q;
    move_y1_d     = move_y1_q;
    move_x2_d     = move_x2_q;
    move_y2_d     = move_y2_q;
    move_single_d = move_single_q;
    err_valid_d   = 1'b0;
    err_code_d    = err_code_q;

    case (fetch_q)
      F_IDLE:  if ((fifo_cnt != 7'd0) && !move_valid_q) fetch_d = F_RD;
      F_RD:    fetch_d = F_CAP;
      F_CAP:   fetch_d = F_GAP1;
      F_GAP1:  fetch_d = F_GAP2;
      F_GAP2:  fetch_d = F_IDLE;
      default: fetch_d = F_IDLE;
    endcase

    if (move_valid_q && move_ready) move_valid_d = 1'b0;

    // A captured byte wins over a simultaneous timeout: it arrived in time.
    if (byte_stb) begin
      tmo_d = 32'd0;
    end else if ((idx_q != 3'd0) && !move_valid_q) begin
      if (tmo_q >= TMO_LAST) begin
        tmo_d       = 32'd0;
        idx_d       = 3'd0;
        err_valid_d = 1'b1;
        err_code_d  = ERR_TMO;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end

    if (byte_stb) begin
      case (idx_q)
        3'd0: if (rx_byte == SYNC_BYTE) idx_d = 3'd1;
        3'd1: begin x1_d = rx_byte; idx_d = 3'd2; end
        3'd2: begin y1_d = rx_byte; idx_d = 3'd3; end
        3'd3: begin x2_d = rx_byte; idx_d = 3'd4; end
        3'd4: begin y2_d = rx_byte; idx_d = 3'd5; end
        default: begin
          idx_d = 3'd0;
          if (!chk_ok) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_CHK;
          end else if (!range_ok) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_RANGE;
          end else begin
            move_valid_d  = 1'b1;
            move_x1_d     = x1_q[4:0];
            move_y1_d     = y1_q[4:0];
            move_x2_d     = single ? 5'd0 : x2_q[4:0];
            move_y2_d     = single ? 5'd0 : y2_q[4:0];
            move_single_d = single;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_q       <= F_IDLE;
      idx_q         <= 3'd0;
      x1_q          <= 8'd0;
      y1_q          <= 8'd0;
      x2_q          <= 8'd0;
      y2_q          <= 8'd0;
      tmo_q         <= 32'd0;
      move_valid_q  <= 1'b0;
      move_x1_q     <= 5'd0;
      move_y1_q     <= 5'd0;
      move_x2_q     <= 5'd0;
      move_y2_q     <= 5'd0;
      move_single_q <= 1'b0;
      err_valid_q   <= 1'b0;
      err_code_q    <= 2'b00;
    end else begin
      fetch_q       <= fetch_d;
      idx_q         <= idx_d;
      x1_q          <= x1_d;
      y1_q          <= y1_d;
      x2_q          <= x2_d;
      y2_q          <= y2_d;
      tmo_q         <= tmo_d;
      move_valid_q  <= move_valid_d;
      move_x1_q     <= move_x1_d;
      move_y1_q     <= move_y1_d;
      move_x2_q     <= move_x2_d;
      move_y2_q     <= move_y2_d;
      move_single_q <= move_single_d;
      err_valid_q   <= err_valid_d;
      err_code_q    <= err_code_d;
    end
  end

  assign uart_read   = (fetch_q == F_RD);
  assign move_valid  = move_valid_q;
  assign move_x1     = move_x1_q;
  assign move_y1     = move_y1_q;
  assign move_x2     = move_x2_q;
  assign move_y2     = move_y2_q;
  assign move_single = move_single_q;
  assign err_valid   = err_valid_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_connect6_move_rx.sv
// Directed bench for connect6_move_rx with a simple registered-read FIFO model
// standing in for the RS232 core.
module tb_connect6_move_rx;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] uart_readdata;
  logic        uart_read;
  logic        move_valid;
  logic        move_ready = 1'b0;
  logic [4:0]  mx1, my1, mx2, my2;
  logic        move_single;
  logic        err_valid;
  logic [1:0]  err_code;

  logic [7:0] mem [0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] data_q = 8'h00;

  int cyc = 0, rd_n = 0, mv_n = 0, err_n = 0, both_n = 0;
  int rd_t [0:255];
  int mv_seen = 0;
  int checks = 0, errors = 0;

  connect6_move_rx #(.BOARD_SIZE(19), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .uart_readdata(uart_readdata),
    .uart_read(uart_read), .move_valid(move_valid), .move_ready(move_ready),
    .move_x1(mx1), .move_y1(my1), .move_x2(mx2), .move_y2(my2),
    .move_single(move_single), .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  assign uart_readdata = {9'd0, 7'(wr_ptr - rd_ptr), 8'd0, data_q};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (uart_read) begin
      data_q       <= mem[rd_ptr[7:0]];
      rd_ptr       <= rd_ptr + 1;
      rd_t[rd_n[7:0]] <= cyc;
      rd_n         <= rd_n + 1;
    end
    if (move_valid && move_ready) mv_n <= mv_n + 1;
    if (err_valid) err_n <= err_n + 1;
    if (err_valid && move_valid) both_n <= both_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask

  task automatic push6(input logic [7:0] a, b, c, d, e, f);
    push(a); push(b); push(c); push(d); push(e); push(f);
  endtask

  task automatic wait_move(input string tag);
    int k = 0;
    do begin @(negedge clk); k++; end while (!move_valid && k < 600);
    check(tag, {31'd0, move_valid}, 32'd1);
    mv_seen = cyc;
  endtask

  task automatic wait_err(input string tag);
    int k = 0;
    do begin @(negedge clk); k++; end while (!err_valid && k < 600);
    check(tag, {31'd0, err_valid}, 32'd1);
  endtask

  task automatic check_move(input string tag, input logic [4:0] x1, y1, x2, y2,
                            input logic s);
    check({tag, "_x1"}, {27'd0, mx1}, {27'd0, x1});
    check({tag, "_y1"}, {27'd0, my1}, {27'd0, y1});
    check({tag, "_x2"}, {27'd0, mx2}, {27'd0, x2});
    check({tag, "_y2"}, {27'd0, my2}, {27'd0, y2});
    check({tag, "_single"}, {31'd0, move_single}, {31'd0, s});
  endtask

  initial begin
    int base_rd, base_mv, base_err, k;
    logic stable;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_uart_read", {31'd0, uart_read}, 32'd0);
    check("rst_move_valid", {31'd0, move_valid}, 32'd0);
    check_move("rst", 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("rst_err_valid", {31'd0, err_valid}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_no_read", rd_n, 0);

    // Single valid move, consumer already ready
    move_ready = 1'b1;
    push6(8'hA5, 8'h03, 8'h04, 8'h05, 8'h06, 8'h04);
    wait_move("m1_valid");
    check_move("m1", 5'd3, 5'd4, 5'd5, 5'd6, 1'b0);
    check("m1_reads", rd_n, 6);
    check("m1_space_first", rd_t[1] - rd_t[0], 5);
    check("m1_space_last", rd_t[5] - rd_t[4], 5);
    check("m1_span", rd_t[5] - rd_t[0], 25);
    check("m1_valid_after_cap", mv_seen - rd_t[5], 2);
    @(negedge clk);
    check("m1_one_cycle", {31'd0, move_valid}, 32'd0);
    check("m1_transfers", mv_n, 1);

    // Single stone
    push6(8'hA5, 8'h09, 8'h09, 8'hFF, 8'hFF, 8'h00);
    wait_move("single_valid");
    check_move("single", 5'd9, 5'd9, 5'd0, 5'd0, 1'b1);

    // Largest legal coordinate, second stone at origin
    push6(8'hA5, 8'h12, 8'h12, 8'h00, 8'h00, 8'h00);
    wait_move("edge_valid");
    check_move("edge", 5'd18, 5'd18, 5'd0, 5'd0, 1'b0);
    @(negedge clk);

    // Error frames
    base_mv = mv_n;
    push6(8'hA5, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00);
    wait_err("chk_err_seen");
    check("chk_err_code", {30'd0, err_code}, 32'd1);
    @(negedge clk);
    check("chk_err_pulse", {31'd0, err_valid}, 32'd0);
    check("chk_err_hold", {30'd0, err_code}, 32'd1);
    push6(8'hA5, 8'h13, 8'h04, 8'h05, 8'h06, 8'h14);
    wait_err("x1_range_seen");
    check("x1_range_code", {30'd0, err_code}, 32'd2);
    push6(8'hA5, 8'h03, 8'h04, 8'h03, 8'h04, 8'h00);
    wait_err("same_cell_seen");
    check("same_cell_code", {30'd0, err_code}, 32'd2);
    push6(8'hA5, 8'h03, 8'h04, 8'hFF, 8'h06, 8'hFE);
    wait_err("half_ff_seen");
    check("half_ff_code", {30'd0, err_code}, 32'd2);
    repeat (3) @(negedge clk);
    check("errs_no_move", mv_n, base_mv);

    // Leading junk is dropped silently
    base_err = err_n;
    push(8'h00); push(8'h7F);
    push6(8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
    wait_move("junk_valid");
    check_move("junk", 5'd1, 5'd2, 5'd3, 5'd4, 1'b0);
    check("junk_no_err", err_n, base_err);
    @(negedge clk);

    // Inter-byte timeout, then recovery
    push(8'hA5); push(8'h03);
    wait_err("tmo_seen");
    check("tmo_code", {30'd0, err_code}, 32'd3);
    push6(8'hA5, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0C);
    wait_move("tmo_rec_valid");
    check_move("tmo_rec", 5'd7, 5'd8, 5'd9, 5'd10, 1'b0);
    @(negedge clk);

    // Backpressure with two frames queued
    move_ready = 1'b0;
    push6(8'hA5, 8'h01, 8'h01, 8'h02, 8'h02, 8'h00);
    push6(8'hA5, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0C);
    wait_move("bp1_valid");
    check_move("bp1", 5'd1, 5'd1, 5'd2, 5'd2, 1'b0);
    base_rd = rd_n;
    stable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!move_valid || mx1 != 5'd1 || my1 != 5'd1 || mx2 != 5'd2 || my2 != 5'd2)
        stable = 1'b0;
    end
    check("bp_stable", {31'd0, stable}, 32'd1);
    check("bp_no_read", rd_n, base_rd);
    base_mv = mv_n;
    move_ready = 1'b1;
    @(negedge clk);
    check("bp_released", {31'd0, move_valid}, 32'd0);
    check("bp_transfer", mv_n, base_mv + 1);
    wait_move("bp2_valid");
    check_move("bp2", 5'd5, 5'd6, 5'd7, 5'd8, 1'b0);
    check("bp2_reads", rd_n - base_rd, 6);
    @(negedge clk);

    // Reset after byte idx2 of a frame
    base_rd = rd_n;
    push6(8'hA5, 8'h03, 8'h04, 8'h05, 8'h06, 8'h04);
    k = 0;
    while (rd_n < base_rd + 3 && k < 200) begin @(negedge clk); k++; end
    check("rst_mid_reached", {31'd0, (rd_n >= base_rd + 3)}, 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst2_uart_read", {31'd0, uart_read}, 32'd0);
    check("rst2_move_valid", {31'd0, move_valid}, 32'd0);
    check_move("rst2", 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("rst2_err_valid", {31'd0, err_valid}, 32'd0);
    check("rst2_err_code", {30'd0, err_code}, 32'd0);
    reset_n = 1'b1;
    base_err = err_n;
    push6(8'hA5, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h04);
    wait_move("post_rst_valid");
    check_move("post_rst", 5'd11, 5'd12, 5'd13, 5'd14, 1'b0);
    check("post_rst_no_err", err_n, base_err);
    check("post_rst_fifo_drained", rd_ptr, wr_ptr);
    @(negedge clk);

    check("never_both", both_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
